cond_check_unit: RTL and testbench

//  Consumer end of the ALU flag interface. Holds the architectural flag register
//  (NZCV) written from the ALU 4-bit flag bus and evaluates each instruction's
//  4-bit condition field against it. Registered pass/fail goes to the execute/WB

---
 rtl/cond_check_unit.sv | 65 ++++++
 tb/tb_cond_check_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cond_check_unit.sv
// cond_check_unit: NZCV flag register plus registered condition-code evaluation with exec/skip counters.
// Optional FLAG_FWD_EN forwards same-cycle alu_flag writes into the evaluation.
module cond_check_unit #(
  parameter int CNT_W = 16,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       alu_flag,
  input  logic             flag_we,
  input  logic             in_valid,
  input  logic [3:0]       cond,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       nzcv,
  output logic             out_valid,
  output logic             cond_pass,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);
  logic [3:0] f;
  logic z, c, n, v, base, pass, load;
`ifdef FLAG_FWD_EN
  assign f = (flag_we && !stall) ? alu_flag : nzcv;
`else
  assign f = nzcv;
`endif
  assign {v, n, c, z} = f;
  // Odd codes are the complement of the even code below them; NV is the complement of AL.
  always_comb begin
    base = 1'b1;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = n ~^ v;
      3'd6: base = ~z & (n ~^ v);
      default: base = 1'b1;
    endcase
    pass = base ^ cond[0];
  end
  assign load = !flush && !stall && in_valid;
  always_ff @(posedge clk) begin
    if (!rst) begin
      nzcv      <= RESET_FLAGS;
      out_valid <= 1'b0;
      cond_pass <= 1'b0;
      exec_cnt  <= '0;
      skip_cnt  <= '0;
    end else begin
      if (flag_we && !stall) nzcv <= alu_flag;
      if (flush) begin
        out_valid <= 1'b0;
        cond_pass <= 1'b0;
      end else if (!stall) begin
        out_valid <= in_valid;
        cond_pass <= in_valid & pass;
      end
      if (load && pass && exec_cnt != '1) exec_cnt <= exec_cnt + CNT_W'(1);
      if (load && !pass && skip_cnt != '1) skip_cnt <= skip_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cond_check_unit.sv
// tb_cond_check_unit: directed vectors with hand-computed expectations for cond_check_unit (CNT_W=4).
module tb_cond_check_unit;
  logic clk = 0, rst, flag_we, in_valid, stall, flush;
  logic [3:0] alu_flag, cond, nzcv;
  logic out_valid, cond_pass;
  logic [3:0] exec_cnt, skip_cnt;
  int vec = 0, miss = 0, ex = 0, sk = 0;
  logic exp4;

  cond_check_unit #(.CNT_W(4), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst(rst), .alu_flag(alu_flag), .flag_we(flag_we), .in_valid(in_valid),
    .cond(cond), .stall(stall), .flush(flush), .nzcv(nzcv), .out_valid(out_valid),
    .cond_pass(cond_pass), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setflags(input logic [3:0] fl);
    flag_we = 1; alu_flag = fl; in_valid = 0;
    tick();
    flag_we = 0;
    chk("flag_write", {28'd0, nzcv}, {28'd0, fl});
  endtask

  task automatic ev(input string tag, input logic [3:0] c, input logic exp);
    in_valid = 1; cond = c;
    tick();
    in_valid = 0;
    chk(tag, {31'd0, cond_pass}, {31'd0, exp});
    if (exp) ex++; else sk++;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_exec"}, {28'd0, exec_cnt}, ex);
    chk({tag, "_skip"}, {28'd0, skip_cnt}, sk);
  endtask

  initial begin
    rst = 0; flag_we = 0; in_valid = 0; stall = 0; flush = 0; alu_flag = 0; cond = 0;
    tick(); tick();
    chk("rst_nzcv", {28'd0, nzcv}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_pass", {31'd0, cond_pass}, 0);
    chk_cnt("rst");
    rst = 1;

    setflags(4'b0001);
    ev("eq_z1", 4'b0000, 1);
    chk("eq_valid", {31'd0, out_valid}, 1);
    ev("ne_z1", 4'b0001, 0);
    cond = 4'b1110;
    tick();
    chk("al_invalid_pass", {31'd0, cond_pass}, 0);
    chk("al_invalid_valid", {31'd0, out_valid}, 0);
    chk_cnt("t2");

    setflags(4'b1100);
    ev("ge_nv11", 4'b1010, 1);
    ev("lt_nv11", 4'b1011, 0);
    ev("gt_nv11", 4'b1100, 1);
    setflags(4'b0100);
    ev("ge_n1v0", 4'b1010, 0);
    ev("le_n1v0", 4'b1101, 1);
    setflags(4'b0010);
    ev("hi_c1", 4'b1000, 1);
    setflags(4'b0011);
    ev("ls_c1z1", 4'b1001, 1);
    ev("al", 4'b1110, 1);
    ev("nv", 4'b1111, 0);
    chk_cnt("t3");

    setflags(4'b0000);
`ifdef FLAG_FWD_EN
    exp4 = 1;
`else
    exp4 = 0;
`endif
    flag_we = 1; alu_flag = 4'b0001; in_valid = 1; cond = 4'b0000;
    tick();
    flag_we = 0; in_valid = 0;
    chk("fwd_pass", {31'd0, cond_pass}, {31'd0, exp4});
    chk("fwd_nzcv", {28'd0, nzcv}, 4'b0001);
    if (exp4) ex++; else sk++;

    stall = 1; flag_we = 1; alu_flag = 4'b1010; in_valid = 1; cond = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_nzcv", {28'd0, nzcv}, 4'b0001);
      chk("stall_valid", {31'd0, out_valid}, 1);
      chk("stall_pass", {31'd0, cond_pass}, {31'd0, exp4});
      chk_cnt("stall");
    end
    flush = 1;
    tick();
    chk("flush_stall_valid", {31'd0, out_valid}, 0);
    chk("flush_stall_pass", {31'd0, cond_pass}, 0);
    chk("flush_stall_nzcv", {28'd0, nzcv}, 4'b0001);
    stall = 0;
    tick();
    chk("flush_nzcv_write", {28'd0, nzcv}, 4'b1010);
    chk("flush_valid", {31'd0, out_valid}, 0);
    chk_cnt("flush");
    flush = 0; flag_we = 0;

    rst = 0; in_valid = 1; cond = 4'b1110;
    tick();
    ex = 0; sk = 0;
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_nzcv", {28'd0, nzcv}, 0);
    chk_cnt("midrst");
    rst = 1;
    repeat (20) tick();
    chk("sat_exec", {28'd0, exec_cnt}, 15);
    chk("sat_skip", {28'd0, skip_cnt}, 0);
    cond = 4'b1111;
    tick();
    in_valid = 0;
    chk("nv_pass", {31'd0, cond_pass}, 0);
    chk("nv_skip", {28'd0, skip_cnt}, 1);
    chk("nv_exec", {28'd0, exec_cnt}, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
